// File: rtl/sram_req_pipe.sv
// sram_req_pipe: request/response adapter in front of a fixed-latency SRAM macro.
// Accepted requests go straight to the SRAM. A tag pipe follows each access
// until its read data returns, and the result is then queued in a small
// response FIFO. A credit counter bounds the number of accepted-but-unpopped
// requests to the FIFO depth, so the FIFO cannot overflow even if the
// consumer stalls.
module sram_req_pipe #(
    parameter int abits                = 17,
    parameter int log2_dbytes          = 3,
    parameter int latency              = 2,
    parameter int cfg_sysbus_addr_bits = 32,
    localparam int dbits               = 8 << log2_dbytes,
    localparam int sbits               = dbits / 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req_valid,
    input  logic [cfg_sysbus_addr_bits-1:0] i_req_addr,
    input  logic                            i_req_write,
    input  logic [dbits-1:0]                i_req_wdata,
    input  logic [sbits-1:0]                i_req_wstrb,
    output logic                            o_req_ready,
    output logic                            o_resp_valid,
    output logic [dbits-1:0]                o_resp_rdata,
    output logic                            o_resp_err,
    input  logic                            i_resp_ready,
    output logic                            o_mem_cs,
    output logic [abits-1:0]                o_mem_addr,
    output logic                            o_mem_wena,
    output logic [sbits-1:0]                o_mem_wstrb,
    output logic [dbits-1:0]                o_mem_wdata,
    input  logic [dbits-1:0]                i_mem_rdata
);

    localparam int depth = latency + 2;
    localparam int cbits = $clog2(depth + 1);
    localparam int pbits = $clog2(depth);

    logic [cbits-1:0]   cnt_q, cnt_d;
    logic [cbits-1:0]   fcnt_q, fcnt_d;
    logic [pbits-1:0]   wptr_q, wptr_d;
    logic [pbits-1:0]   rptr_q, rptr_d;
    logic [latency-1:0] tv_q, tv_d;
    logic [latency-1:0] tw_q, tw_d;
    logic [latency-1:0] te_q, te_d;
    logic [dbits-1:0]   fdata_q [depth];
    logic [dbits-1:0]   fdata_d [depth];
    logic [depth-1:0]   ferr_q, ferr_d;

    logic             oor;
    logic             acc;
    logic             push;
    logic             pop;
    logic [dbits-1:0] push_data;

    function automatic logic [pbits-1:0] ptr_inc(input logic [pbits-1:0] p);
        ptr_inc = (p == pbits'(depth - 1)) ? '0 : p + pbits'(1);
    endfunction

    // Request side: ready depends only on the credit register, never on live inputs.
    always_comb begin
        oor         = |i_req_addr[cfg_sysbus_addr_bits-1:abits];
        o_req_ready = (cnt_q < cbits'(depth));
        acc         = i_req_valid & o_req_ready;
        o_mem_cs    = acc & ~oor;
        o_mem_wena  = o_mem_cs & i_req_write;
        o_mem_addr  = i_req_addr[abits-1:0];
        o_mem_wstrb = i_req_wstrb;
        o_mem_wdata = i_req_wdata;
    end

    // Response side: the FIFO head drives the outputs, forced to zero while empty.
    always_comb begin
        o_resp_valid = (fcnt_q != '0);
        o_resp_rdata = o_resp_valid ? fdata_q[rptr_q] : '0;
        o_resp_err   = o_resp_valid & ferr_q[rptr_q];
        pop          = o_resp_valid & i_resp_ready;
        push         = tv_q[latency-1];
        // Writes and out-of-range accesses never drove the SRAM, so their data is forced to 0.
        push_data    = (~tw_q[latency-1] & ~te_q[latency-1]) ? i_mem_rdata : '0;
    end

    // Tag pipe: shift the {valid, write, error} tag of each access by one stage per cycle.
    always_comb begin
        tv_d    = tv_q;
        tw_d    = tw_q;
        te_d    = te_q;
        tv_d[0] = acc;
        tw_d[0] = i_req_write;
        te_d[0] = oor;
        for (int i = 1; i < latency; i++) begin
            tv_d[i] = tv_q[i-1];
            tw_d[i] = tw_q[i-1];
            te_d[i] = te_q[i-1];
        end
    end

    // FIFO and credit bookkeeping; push and pop may coincide at any occupancy.
    always_comb begin
        fdata_d = fdata_q;
        ferr_d  = ferr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            fdata_d[wptr_q] = push_data;
            ferr_d[wptr_q]  = te_q[latency-1];
            wptr_d          = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        fcnt_d = fcnt_q + cbits'(push) - cbits'(pop);
        cnt_d  = cnt_q + cbits'(acc) - cbits'(pop);
    end

    // State registers; reset discards every in-flight and buffered response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= '0;
            fcnt_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            tv_q   <= '0;
            tw_q   <= '0;
            te_q   <= '0;
            ferr_q <= '0;
            for (int i = 0; i < depth; i++) begin
                fdata_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            tv_q    <= tv_d;
            tw_q    <= tw_d;
            te_q    <= te_d;
            ferr_q  <= ferr_d;
            fdata_q <= fdata_d;
        end
    end

endmodule

// File: tb/tb_sram_req_pipe.sv
// Directed testbench for sram_req_pipe (latency 2, 64-bit data, depth 4).
module tb_sram_req_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_write;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_wstrb;
    logic        o_req_ready;
    logic        o_resp_valid;
    logic [63:0] o_resp_rdata;
    logic        o_resp_err;
    logic        i_resp_ready;
    logic        o_mem_cs;
    logic [16:0] o_mem_addr;
    logic        o_mem_wena;
    logic [7:0]  o_mem_wstrb;
    logic [63:0] o_mem_wdata;
    logic [63:0] i_mem_rdata;

    int total = 0;
    int bad   = 0;

    sram_req_pipe dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_write  (i_req_write),
        .i_req_wdata  (i_req_wdata),
        .i_req_wstrb  (i_req_wstrb),
        .o_req_ready  (o_req_ready),
        .o_resp_valid (o_resp_valid),
        .o_resp_rdata (o_resp_rdata),
        .o_resp_err   (o_resp_err),
        .i_resp_ready (i_resp_ready),
        .o_mem_cs     (o_mem_cs),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wena   (o_mem_wena),
        .o_mem_wstrb  (o_mem_wstrb),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: two-cycle read latency, byte-masked writes.
    logic [63:0] mem [0:1023];
    logic [63:0] rd_p0, rd_p1;
    logic [9:0]  mem_idx;
    assign mem_idx     = o_mem_addr[12:3];
    assign i_mem_rdata = rd_p1;

    always @(posedge clk) begin
        if (o_mem_cs) begin
            if (o_mem_wena) begin
                for (int b = 0; b < 8; b++) begin
                    if (o_mem_wstrb[b]) mem[mem_idx][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
                end
            end
            rd_p0 <= mem[mem_idx];
        end else begin
            rd_p0 <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
        rd_p1 <= rd_p0;
    end

    // Credits never exceed depth and never fall below the buffered count.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (dut.cnt_q > 4 || dut.fcnt_q > dut.cnt_q) begin
                bad++;
                $display("FAIL credit_invariant: cnt=%0d fifo=%0d limit=4", dut.cnt_q, dut.fcnt_q);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Returns the cycle index (accept cycle = 0) in which o_resp_valid first shows; -1 on timeout.
    task automatic wait_resp(output int n);
        n = 1;
        while (!o_resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_resp_valid) n = -1;
    endtask

    task automatic send(input logic [31:0] addr, input logic wr,
                        input logic [63:0] wdata, input logic [7:0] wstrb);
        int guard;
        guard       = 0;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_write = wr;
        i_req_wdata = wdata;
        i_req_wstrb = wstrb;
        while (!o_req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [63:0] data);
        int n;
        send(addr, 1'b1, data, 8'hFF);
        wait_resp(n);
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        i_req_write  = 1'b0;
        i_req_wdata  = '0;
        i_req_wstrb  = '0;
        i_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", o_req_ready); end
        total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", o_resp_valid); end
        total++; if (o_resp_rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %0h want 0", o_resp_rdata); end
        total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", o_resp_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read;
        int n;
        fill(32'h40, 64'h1122_3344_5566_7788);
        i_req_valid = 1'b1;
        i_req_addr  = 32'h40;
        i_req_write = 1'b0;
        #1;
        total++; if (o_mem_cs !== 1'b1) begin bad++; $display("FAIL read_cs: got %0b want 1", o_mem_cs); end
        total++; if (o_mem_wena !== 1'b0) begin bad++; $display("FAIL read_wena: got %0b want 0", o_mem_wena); end
        total++; if (o_mem_addr !== 17'h40) begin bad++; $display("FAIL read_addr: got %0h want 40", o_mem_addr); end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        wait_resp(n);
        total++; if (n != 3) begin bad++; $display("FAIL read_latency: got cycle %0d want 3", n); end
        total++; if (o_resp_rdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL read_data: got %0h want 1122334455667788", o_resp_rdata); end
        total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL read_err: got %0b want 0", o_resp_err); end
    endtask

    task automatic test_write_read;
        int n;
        fill(32'h80, 64'h0102_0304_0506_0708);
        i_req_valid = 1'b1;
        i_req_addr  = 32'h80;
        i_req_write = 1'b1;
        i_req_wdata = 64'hAABB_CCDD_EEFF_0011;
        i_req_wstrb = 8'h0F;
        #1;
        total++; if (o_mem_wena !== 1'b1) begin bad++; $display("FAIL write_wena: got %0b want 1", o_mem_wena); end
        total++; if (o_mem_wstrb !== 8'h0F) begin bad++; $display("FAIL write_strb: got %0h want 0f", o_mem_wstrb); end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        wait_resp(n);
        total++; if (n != 3) begin bad++; $display("FAIL write_latency: got cycle %0d want 3", n); end
        total++; if (o_resp_rdata !== 64'h0) begin bad++; $display("FAIL write_rdata: got %0h want 0", o_resp_rdata); end
        total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL write_err: got %0b want 0", o_resp_err); end
        send(32'h80, 1'b0, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (o_resp_rdata !== 64'h0102_0304_EEFF_0011) begin bad++; $display("FAIL merged_read: got %0h want 01020304eeff0011", o_resp_rdata); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_d [16];
        int idx, last, c;
        for (int i = 0; i < 16; i++) begin
            exp_d[i] = {32'(32'hC0DE_0000 + i), 32'(32'h0BAD_0000 + i * 3)};
            fill(32'(32'h100 + i * 8), exp_d[i]);
        end
        @(posedge clk); #1;
        i_resp_ready = 1'b1;
        idx  = 0;
        last = -1;
        c    = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    i_req_valid = 1'b1;
                    i_req_addr  = 32'(32'h100 + i * 8);
                    i_req_write = 1'b0;
                    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: req %0d got %0b want 1", i, o_req_ready); end
                    @(posedge clk); #1;
                end
                i_req_valid = 1'b0;
            end
            begin
                while (idx < 16 && c < 60) begin
                    if (o_resp_valid) begin
                        total++; if (o_resp_rdata !== exp_d[idx]) begin bad++; $display("FAIL b2b_data: resp %0d got %0h want %0h", idx, o_resp_rdata, exp_d[idx]); end
                        if (idx > 0) begin
                            total++; if (c != last + 1) begin bad++; $display("FAIL b2b_gap: resp %0d at cycle %0d want %0d", idx, c, last + 1); end
                        end
                        last = c;
                        idx++;
                    end
                    @(posedge clk); #1;
                    c++;
                end
                total++; if (idx != 16) begin bad++; $display("FAIL b2b_count: got %0d responses want 16", idx); end
            end
        join
    endtask

    task automatic test_stall;
        logic [63:0] exp_d [4];
        int acc_n;
        logic r;
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = {32'(32'h5A5A_0000 + i), 32'(32'hF00D_0000 + i)};
            fill(32'(32'h200 + i * 8), exp_d[i]);
        end
        @(posedge clk); #1;
        i_resp_ready = 1'b0;
        i_req_valid  = 1'b1;
        i_req_write  = 1'b0;
        acc_n        = 0;
        for (int c = 0; c < 10; c++) begin
            i_req_addr = 32'(32'h200 + acc_n * 8);
            r = o_req_ready;
            @(posedge clk); #1;
            if (r) acc_n++;
        end
        total++; if (acc_n != 4) begin bad++; $display("FAIL stall_accepted: got %0d want 4", acc_n); end
        total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %0b want 0", o_req_ready); end
        total++; if (o_resp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %0b want 1", o_resp_valid); end
        i_req_valid  = 1'b0;
        i_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (o_resp_valid !== 1'b1 || o_resp_rdata !== exp_d[k]) begin bad++; $display("FAIL stall_drain: entry %0d valid %0b data %0h want %0h", k, o_resp_valid, o_resp_rdata, exp_d[k]); end
            @(posedge clk); #1;
        end
        total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_back: got %0b want 1", o_req_ready); end
        total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: got %0b want 0", o_resp_valid); end
    endtask

    task automatic test_oor;
        int n;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0002_0000;
        i_req_write = 1'b0;
        #1;
        total++; if (o_mem_cs !== 1'b0) begin bad++; $display("FAIL oor_cs: got %0b want 0", o_mem_cs); end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        wait_resp(n);
        total++; if (n != 3) begin bad++; $display("FAIL oor_latency: got cycle %0d want 3", n); end
        total++; if (o_resp_err !== 1'b1) begin bad++; $display("FAIL oor_err: got %0b want 1", o_resp_err); end
        total++; if (o_resp_rdata !== 64'h0) begin bad++; $display("FAIL oor_rdata: got %0h want 0", o_resp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        int n;
        fill(32'h10, 64'h0F0E_0D0C_0B0A_0908);
        @(posedge clk); #1;
        i_req_valid = 1'b1;
        i_req_write = 1'b0;
        i_req_addr  = 32'h40;
        @(posedge clk); #1;
        i_req_addr  = 32'h80;
        @(posedge clk); #1;
        i_req_addr  = 32'h100;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        total++; if (o_resp_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %0b want 1", o_resp_valid); end
        rst = 1'b1;
        #1;
        total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %0b want 0", o_resp_valid); end
        total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %0b want 1", o_req_ready); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(32'h10, 1'b0, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (n != 3) begin bad++; $display("FAIL post_reset_latency: got cycle %0d want 3", n); end
        total++; if (o_resp_rdata !== 64'h0F0E_0D0C_0B0A_0908) begin bad++; $display("FAIL post_reset_data: got %0h want 0f0e0d0c0b0a0908", o_resp_rdata); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_oor();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_req_pipe.md
Name: sram_req_pipe

Overview:
- Request/response adapter between the axi_slv request port and a synchronous SRAM macro whose read data returns `latency` cycles after chip-select.
- Tracks in-flight accesses with a tag shift pipe and buffers returning data in a response FIFO.
- Applies credit-based backpressure, so back-to-back requests sustain one access per cycle with no data loss when the response consumer stalls.
- Also flags out-of-range addresses.

Parameters:
- abits, 17, SRAM word-address-plus-byte-offset width; addresses with bits [CFG_SYSBUS_ADDR_BITS-1:abits] nonzero are out of range.
- log2_dbytes, 3, log2 of data bus bytes; dbits = 8 << log2_dbytes.
- latency, 2, SRAM read latency in cycles, legal range 1..4.
- Derived localparam depth = latency + 2: response FIFO entries and credit limit.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  1  request valid.
- i_req_addr  in  CFG_SYSBUS_ADDR_BITS  byte address.
- i_req_write  in  1  1 = write, 0 = read.
- i_req_wdata  in  dbits  write data.
- i_req_wstrb  in  dbits/8  byte strobes.
- o_req_ready  out  1  request accepted when i_req_valid & o_req_ready.
- o_resp_valid  out  1  response available (FIFO head valid).
- o_resp_rdata  out  dbits  read data; 0 for writes and errors.
- o_resp_err  out  1  out-of-range access.
- i_resp_ready  in  1  consumer pops head when o_resp_valid & i_resp_ready.
- o_mem_cs  out  1  SRAM chip select.
- o_mem_addr  out  abits  SRAM address = i_req_addr[abits-1:0].
- o_mem_wena  out  1  SRAM write enable.
- o_mem_wstrb  out  dbits/8  SRAM byte enables.
- o_mem_wdata  out  dbits  SRAM write data.
- i_mem_rdata  in  dbits  SRAM read data, valid `latency` cycles after a read cs.

Behaviour:
- Reset (async assert, sync release):
  - cnt = 0; tag pipe cleared; FIFO empty.
  - o_req_ready = 1, o_resp_valid = 0, o_resp_rdata = 0, o_resp_err = 0.
- Accept: acc = i_req_valid & o_req_ready.
  - o_req_ready = (cnt < depth); registered-only, no path from i_resp_ready or i_req_valid.
- Memory issue is combinational in the accept cycle:
  - o_mem_cs = acc & ~oor, where oor = |i_req_addr[CFG_SYSBUS_ADDR_BITS-1:abits].
  - o_mem_wena = o_mem_cs & i_req_write.
  - o_mem_addr, o_mem_wstrb and o_mem_wdata pass through; they are don't-care when cs = 0.
- Tag pipe:
  - `latency` stages of {v, wr, err}; stage 0 loads {acc, i_req_write, oor}, one stage shift per cycle.
  - When the last stage has v = 1, push FIFO entry {rdata, err}.
  - rdata = i_mem_rdata for a valid in-range read, else 0.
- FIFO:
  - depth entries with registered head.
  - o_resp_valid = not empty; o_resp_rdata and o_resp_err come from the head.
  - Simultaneous push and pop is allowed at any occupancy, including full and empty (a push into an empty FIFO appears next cycle).
  - Pointers wrap modulo depth.
- Credit counter:
  - cnt += acc, cnt -= pop, both in the same cycle, giving a net change of 0.
  - cnt counts accepted-but-not-popped requests, so the FIFO can never overflow.
  - Overflow or underflow is impossible by construction; the bench asserts this.
- Latency: a request accepted in cycle t gives o_resp_valid in cycle t+latency+1 when the FIFO is empty.
- Throughput: one request per cycle sustained with i_resp_ready held 1.
- Ordering: responses are returned strictly in acceptance order. Writes and errors also produce exactly one response each.
- Stall: with i_resp_ready = 0, the FIFO fills. o_req_ready drops once cnt == depth; in-flight tags still land.
- Reset mid-operation drops all in-flight and buffered responses; the first response after release corresponds to the first request accepted after release.

Test Plan:
- Single read, latency=2, mem[0x40] = 0x1122334455667788: accept at cycle 0 → o_resp_valid at cycle 3, rdata 0x1122334455667788, err 0.
- Write 0xAABB... strb 0x0F to 0x80, then read 0x80 → write response rdata 0 err 0; read returns low 4 bytes updated, upper bytes unchanged.
- 16 back-to-back reads with i_resp_ready = 1 → o_req_ready stays 1; 16 responses in order on consecutive cycles.
- i_resp_ready = 0, continuous requests → exactly depth = 4 accepted, then o_req_ready = 0. Release ready → all 4 drain in order, then o_req_ready returns to 1.
- Address 1 << abits → o_mem_cs = 0; response err = 1, rdata = 0, same latency as a read.
- Assert i_rst with 3 requests in flight → o_resp_valid = 0 immediately; after release, new read 0x10 yields the next response with correct data.
